// File: rtl/sd_req_arbiter_if.sv
// Requester and hps_io SD-block signals shared by the arbiter and its surroundings.
// "master" is the arbiter side; "slave" is the disk cores plus hps_io side.
interface sd_req_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int BUF_DW = 8
);
  logic [NREQ-1:0]        req_rd;
  logic [NREQ-1:0]        req_wr;
  logic [32*NREQ-1:0]     req_lba;
  logic [BUF_DW*NREQ-1:0] req_buff_din;
  logic [NREQ-1:0]        req_ack;
  logic [NREQ-1:0]        req_buff_wr;
  logic [NREQ-1:0]        req_done;
  logic                   req_err;
  logic [31:0]            sd_lba;
  logic [NREQ-1:0]        sd_rd;
  logic [NREQ-1:0]        sd_wr;
  logic                   sd_ack;
  logic                   sd_buff_wr;
  logic [BUF_DW-1:0]      sd_buff_din;

  modport master (
    input  req_rd, req_wr, req_lba, req_buff_din, sd_ack, sd_buff_wr,
    output req_ack, req_buff_wr, req_done, req_err, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport slave (
    output req_rd, req_wr, req_lba, req_buff_din, sd_ack, sd_buff_wr,
    input  req_ack, req_buff_wr, req_done, req_err, sd_lba, sd_rd, sd_wr, sd_buff_din
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin share of one hps_io SD block port among NREQ disk cores; sd_rd/sd_wr rise 1 cycle after grant.
// Buffer strobes/data are routed combinationally during XFER; losers simply hold their level request.
module sd_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int BUF_AW  = 9,
  parameter int BUF_DW  = 8,
  parameter int TIMEOUT = 0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  sd_req_arbiter_if.master  bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = GW + 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       sd_lba_q, sd_lba_d;
  logic [NREQ-1:0]   sd_rd_q, sd_rd_d;
  logic [NREQ-1:0]   sd_wr_q, sd_wr_d;

  logic [NREQ-1:0]   pending;
  logic [NREQ-1:0]   grant_oh;
  logic [NREQ-1:0]   sel_oh;
  logic              found;
  logic [GW-1:0]     sel;
  logic [SW-1:0]     sum;

  // First pending requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    pending = bus.req_rd | bus.req_wr;
    found   = 1'b0;
    sel     = '0;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (!found && pending[sum[GW-1:0]]) begin
        found = 1'b1;
        sel   = sum[GW-1:0];
      end
    end
  end

  assign grant_oh = NREQ'(1) << grant_q;
  assign sel_oh   = NREQ'(1) << sel;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    sd_lba_d = sd_lba_q;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = sel;
          sd_lba_d = bus.req_lba[sel*32 +: 32];
          sd_rd_d  = bus.req_rd[sel] ? sel_oh : '0;
          sd_wr_d  = bus.req_rd[sel] ? '0 : sel_oh;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.sd_ack) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          state_d = XFER;
        end else if (TIMEOUT > 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      XFER: begin
        if (!bus.sd_ack) state_d = DONE;
      end
      DONE: begin
        rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      sd_lba_q <= '0;
      sd_rd_q  <= '0;
      sd_wr_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      sd_lba_q <= sd_lba_d;
      sd_rd_q  <= sd_rd_d;
      sd_wr_q  <= sd_wr_d;
    end
  end

  assign bus.sd_lba = sd_lba_q;
  assign bus.sd_rd  = sd_rd_q;
  assign bus.sd_wr  = sd_wr_q;

  // Stale sd_ack / sd_buff_wr outside XFER must never reach a requester.
  always_comb begin
    bus.req_ack     = '0;
    bus.req_buff_wr = '0;
    bus.sd_buff_din = '0;
    bus.req_done    = '0;
    bus.req_err     = 1'b0;
    if (state_q == XFER) begin
      bus.req_ack     = bus.sd_ack     ? grant_oh : '0;
      bus.req_buff_wr = bus.sd_buff_wr ? grant_oh : '0;
      bus.sd_buff_din = bus.req_buff_din[grant_q*BUF_DW +: BUF_DW];
    end
    if (state_q == DONE) begin
      bus.req_done = grant_oh;
      bus.req_err  = err_q;
    end
  end

  a_one_cmd:  assert property (@(posedge clk_sys) disable iff (!reset_n) $onehot0(bus.sd_rd | bus.sd_wr));
  a_one_bwr:  assert property (@(posedge clk_sys) disable iff (!reset_n) $onehot0(bus.req_buff_wr));
  a_done_cmd: assert property (@(posedge clk_sys) disable iff (!reset_n)
                               !((|bus.req_done) && (|(bus.sd_rd | bus.sd_wr))));
  // The sector buffer is 512 bytes whichever I/O width hps_io uses.
  a_buf_geom: assert property (@(posedge clk_sys) (BUF_AW + BUF_DW / 8) == 10);
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: expected issues/completions are queued as stimulus is driven
// and popped when the arbiter presents them.
module tb_sd_req_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sd_req_arbiter_if #(.NREQ(NREQ), .BUF_DW(DW)) bus ();

  sd_req_arbiter #(.NREQ(NREQ), .BUF_AW(9), .BUF_DW(DW), .TIMEOUT(16)) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic [NREQ-1:0] rd;
    logic [NREQ-1:0] wr;
    logic [31:0]     lba;
  } iss_t;
  typedef struct packed {
    logic [NREQ-1:0] done;
    logic            err;
  } done_t;

  iss_t  iss_q[$];
  done_t done_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input string tag, output int lat);
    iss_t e;
    lat = 0;
    while ((bus.sd_rd | bus.sd_wr) == '0 && lat < 8) begin
      tick();
      lat++;
    end
    chk({tag, "_issue_seen"}, 64'((bus.sd_rd | bus.sd_wr) != '0), 64'(1));
    chk({tag, "_issue_queued"}, 64'(iss_q.size() != 0), 64'(1));
    if (iss_q.size() != 0) begin
      e = iss_q.pop_front();
      chk({tag, "_sd_rd"}, 64'(bus.sd_rd), 64'(e.rd));
      chk({tag, "_sd_wr"}, 64'(bus.sd_wr), 64'(e.wr));
      chk({tag, "_sd_lba"}, 64'(bus.sd_lba), 64'(e.lba));
    end
  endtask

  task automatic wait_done(input string tag);
    done_t e;
    int n = 0;
    while (bus.req_done == '0 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(bus.req_done != '0), 64'(1));
    chk({tag, "_done_queued"}, 64'(done_q.size() != 0), 64'(1));
    if (done_q.size() != 0) begin
      e = done_q.pop_front();
      chk({tag, "_req_done"}, 64'(bus.req_done), 64'(e.done));
      chk({tag, "_req_err"}, 64'(bus.req_err), 64'(e.err));
      chk({tag, "_cmd_clear"}, 64'(bus.sd_rd | bus.sd_wr), 64'(0));
    end
  endtask

  task automatic xfer(input int nwr);
    bus.sd_ack = 1'b1;
    tick();
    for (int i = 0; i < nwr; i++) begin
      bus.sd_buff_wr = 1'b1;
      tick();
    end
    bus.sd_buff_wr = 1'b0;
    bus.sd_ack     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int hi;
    int n_mine;
    int n_other;
    logic [NREQ-1:0] seen;

    bus.req_rd       = '0;
    bus.req_wr       = '0;
    bus.req_lba      = '0;
    bus.req_buff_din = '0;
    bus.sd_ack       = 1'b0;
    bus.sd_buff_wr   = 1'b0;
    tick();
    tick();
    chk("rst_sd_rd", 64'(bus.sd_rd), 64'(0));
    chk("rst_sd_wr", 64'(bus.sd_wr), 64'(0));
    chk("rst_sd_lba", 64'(bus.sd_lba), 64'(0));
    chk("rst_req_done", 64'(bus.req_done), 64'(0));
    chk("rst_sd_buff_din", 64'(bus.sd_buff_din), 64'(0));
    reset_n = 1'b1;
    tick();

    // Read on requester 2 with a full 512-strobe sector.
    bus.req_lba[2*32 +: 32] = 32'h0000_1234;
    bus.req_rd[2] = 1'b1;
    iss_q.push_back('{rd: 4'b0100, wr: 4'b0000, lba: 32'h1234});
    wait_issue("t1", lat);
    chk("t1_latency", 64'(lat), 64'(1));
    bus.sd_ack = 1'b1;
    tick();
    chk("t1_rd_clear", 64'(bus.sd_rd), 64'(0));
    chk("t1_req_ack", 64'(bus.req_ack), 64'(4'b0100));
    n_mine = 0;
    n_other = 0;
    for (int i = 0; i < 512; i++) begin
      bus.sd_buff_wr = 1'b1;
      #1;
      if (bus.req_buff_wr[2]) n_mine++;
      if ((bus.req_buff_wr & 4'b1011) != '0) n_other++;
      tick();
    end
    bus.sd_buff_wr = 1'b0;
    chk("t1_buff_wr_mine", 64'(n_mine), 64'(512));
    chk("t1_buff_wr_other", 64'(n_other), 64'(0));
    bus.sd_ack = 1'b0;
    done_q.push_back('{done: 4'b0100, err: 1'b0});
    wait_done("t1");
    bus.req_rd[2] = 1'b0;
    tick();
    chk("t1_done_one_cycle", 64'(bus.req_done), 64'(0));

    // Round robin: 0 and 1 together, 0 re-raised while 1 is served.
    bus.req_lba[0*32 +: 32] = 32'h0000_00A0;
    bus.req_lba[1*32 +: 32] = 32'h0000_00B1;
    bus.req_rd[1:0] = 2'b11;
    iss_q.push_back('{rd: 4'b0001, wr: 4'b0000, lba: 32'hA0});
    wait_issue("t2a", lat);
    xfer(4);
    done_q.push_back('{done: 4'b0001, err: 1'b0});
    wait_done("t2a");
    bus.req_rd[0] = 1'b0;
    iss_q.push_back('{rd: 4'b0010, wr: 4'b0000, lba: 32'hB1});
    wait_issue("t2b", lat);
    bus.req_rd[0] = 1'b1;
    xfer(4);
    done_q.push_back('{done: 4'b0010, err: 1'b0});
    wait_done("t2b");
    bus.req_rd[1] = 1'b0;
    iss_q.push_back('{rd: 4'b0001, wr: 4'b0000, lba: 32'hA0});
    wait_issue("t2c", lat);
    xfer(2);
    done_q.push_back('{done: 4'b0001, err: 1'b0});
    wait_done("t2c");
    bus.req_rd[0] = 1'b0;
    tick();

    // Write on requester 3: buffer data muxed only during XFER.
    bus.req_lba[3*32 +: 32] = 32'h0000_0033;
    bus.req_buff_din[3*DW +: DW] = 8'hA5;
    bus.req_buff_din[0*DW +: DW] = 8'h11;
    bus.req_wr[3] = 1'b1;
    iss_q.push_back('{rd: 4'b0000, wr: 4'b1000, lba: 32'h33});
    wait_issue("t3", lat);
    chk("t3_din_issue", 64'(bus.sd_buff_din), 64'(0));
    bus.sd_ack = 1'b1;
    tick();
    chk("t3_din_xfer", 64'(bus.sd_buff_din), 64'(8'hA5));
    bus.req_buff_din[3*DW +: DW] = 8'h5A;
    #1;
    chk("t3_din_follow", 64'(bus.sd_buff_din), 64'(8'h5A));
    bus.sd_ack = 1'b0;
    done_q.push_back('{done: 4'b1000, err: 1'b0});
    wait_done("t3");
    bus.req_wr[3] = 1'b0;
    tick();
    chk("t3_din_idle", 64'(bus.sd_buff_din), 64'(0));

    // Timeout: no ack for requester 1.
    bus.req_lba[1*32 +: 32] = 32'h0000_0F01;
    bus.req_rd[1] = 1'b1;
    iss_q.push_back('{rd: 4'b0010, wr: 4'b0000, lba: 32'hF01});
    wait_issue("t4", lat);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.sd_rd[1]) break;
      hi++;
    end
    chk("t4_rd_high_cycles", 64'(hi), 64'(16));
    done_q.push_back('{done: 4'b0010, err: 1'b1});
    wait_done("t4");
    bus.req_rd[1] = 1'b0;
    tick();
    chk("t4_err_cleared", 64'(bus.req_err), 64'(0));

    // Reset in the middle of a transfer.
    bus.req_lba[2*32 +: 32] = 32'h0000_0077;
    bus.req_rd[2] = 1'b1;
    iss_q.push_back('{rd: 4'b0100, wr: 4'b0000, lba: 32'h77});
    wait_issue("t5", lat);
    bus.sd_ack = 1'b1;
    tick();
    bus.sd_buff_wr = 1'b1;
    #1;
    chk("t5_bwr_routed", 64'(bus.req_buff_wr), 64'(4'b0100));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req_rd[2] = 1'b0;
    chk("t5_rst_sd_rd", 64'(bus.sd_rd), 64'(0));
    chk("t5_rst_sd_lba", 64'(bus.sd_lba), 64'(0));
    chk("t5_rst_req_ack", 64'(bus.req_ack), 64'(0));
    chk("t5_rst_buff_wr", 64'(bus.req_buff_wr), 64'(0));
    chk("t5_rst_din", 64'(bus.sd_buff_din), 64'(0));
    bus.sd_buff_wr = 1'b0;
    bus.sd_ack = 1'b0;
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | bus.req_done | bus.sd_rd | bus.sd_wr;
    end
    chk("t5_no_done_after_rst", 64'(seen), 64'(0));

    // Read wins over write; stale ack in IDLE is ignored.
    bus.req_lba[0*32 +: 32] = 32'h0000_0C00;
    bus.req_rd[0] = 1'b1;
    bus.req_wr[0] = 1'b1;
    iss_q.push_back('{rd: 4'b0001, wr: 4'b0000, lba: 32'hC00});
    wait_issue("t6", lat);
    xfer(3);
    done_q.push_back('{done: 4'b0001, err: 1'b0});
    wait_done("t6");
    bus.req_rd[0] = 1'b0;
    bus.req_wr[0] = 1'b0;
    tick();
    bus.sd_ack = 1'b1;
    bus.sd_buff_wr = 1'b1;
    #1;
    chk("t6_stale_ack", 64'(bus.req_ack), 64'(0));
    chk("t6_stale_bwr", 64'(bus.req_buff_wr), 64'(0));
    tick();
    bus.sd_ack = 1'b0;
    bus.sd_buff_wr = 1'b0;
    tick();
    chk("t6_idle_no_cmd", 64'(bus.sd_rd | bus.sd_wr), 64'(0));
    chk("t6_idle_no_done", 64'(bus.req_done), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
